// File: rtl/rewire_cmd_issuer.sv
// Command issuer for the ReWire pipelined state machine.
// Buffers valid/ready commands, drives one word per clock (a NOP bubble when
// idle), tracks real words through the pipeline with a shadow valid chain and
// collects their results into a credit-protected response FIFO.
module rewire_cmd_issuer #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned LAT       = 2,
    parameter logic [9:0]  NOP_WORD  = 10'h300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_data,
    output logic [9:0]  dut_in,
    input  logic [15:0] dut_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy
);

    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RSP_DEPTH);
    localparam int unsigned CRW = $clog2(RSP_DEPTH + 1);

    // Command FIFO; pointers carry one extra bit to tell full from empty.
    logic [9:0]     r_cmd_mem [CMD_DEPTH];
    logic [CAW:0]   r_cmd_wp;
    logic [CAW:0]   r_cmd_rp;
    logic           w_cmd_empty;
    logic           w_cmd_full;
    logic           w_cmd_push;

    // Response FIFO.
    logic [15:0]    r_rsp_mem [RSP_DEPTH];
    logic [RAW:0]   r_rsp_wp;
    logic [RAW:0]   r_rsp_rp;
    logic [RAW:0]   w_rsp_count;
    logic           w_rsp_empty;
    logic           w_rsp_full;
    logic           w_rsp_push;
    logic           w_rsp_pop;

    // Issue path.
    logic [9:0]     r_dut_in;
    logic [LAT-1:0] r_vld;
    logic [LAT-1:0] w_vld_d;
    logic [CRW-1:0] r_credits;
    logic [CRW-1:0] w_credits_d;
    logic           w_issue;

    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = (r_cmd_wp[CAW] != r_cmd_rp[CAW]) &&
                         (r_cmd_wp[CAW-1:0] == r_cmd_rp[CAW-1:0]);
    assign w_cmd_push  = cmd_valid && !w_cmd_full;

    assign w_rsp_count = r_rsp_wp - r_rsp_rp;
    assign w_rsp_empty = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_full  = (r_rsp_wp[RAW] != r_rsp_rp[RAW]) &&
                         (r_rsp_wp[RAW-1:0] == r_rsp_rp[RAW-1:0]);
    // The last shadow stage marks dut_out as a real result this cycle.
    assign w_rsp_push  = r_vld[LAT-1];
    assign w_rsp_pop   = !w_rsp_empty && rsp_ready;

    // A credit is a reserved response slot; without one, nothing may issue.
    assign w_issue     = !w_cmd_empty && (r_credits != '0);

    assign cmd_ready   = !w_cmd_full;
    assign dut_in      = r_dut_in;
    assign rsp_valid   = !w_rsp_empty;
    assign rsp_data    = w_rsp_empty ? 16'h0000 : r_rsp_mem[r_rsp_rp[RAW-1:0]];
    assign busy        = !w_cmd_empty || (r_vld != '0) || !w_rsp_empty;

    // Next shadow chain and credit count.
    always_comb begin
        w_vld_d    = r_vld << 1;
        w_vld_d[0] = w_issue;
        w_credits_d = r_credits;
        unique case ({w_issue, w_rsp_pop})
            2'b10:   w_credits_d = r_credits - CRW'(1);
            2'b01:   w_credits_d = r_credits + CRW'(1);
            default: w_credits_d = r_credits;
        endcase
    end

    // Command FIFO storage (no reset needed; guarded by pointers).
    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wp[CAW-1:0]] <= cmd_data;
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wp[RAW-1:0]] <= dut_out;
        end
    end

    // Pointers, issue register, shadow chain and credits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_dut_in  <= NOP_WORD;
            r_vld     <= '0;
            r_credits <= CRW'(RSP_DEPTH);
        end else begin
            if (w_cmd_push) begin
                r_cmd_wp <= r_cmd_wp + 1'b1;
            end
            if (w_issue) begin
                r_cmd_rp <= r_cmd_rp + 1'b1;
                r_dut_in <= r_cmd_mem[r_cmd_rp[CAW-1:0]];
            end else begin
                r_dut_in <= NOP_WORD;
            end
            if (w_rsp_push) begin
                r_rsp_wp <= r_rsp_wp + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rp <= r_rsp_rp + 1'b1;
            end
            r_vld     <= w_vld_d;
            r_credits <= w_credits_d;
        end
    end

    // Credits must make a capture into a full response FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_rsp_push && w_rsp_full))
                else $error("response captured into full FIFO");
            assert ((int'(r_credits) + int'(w_rsp_count) + $countones(r_vld))
                    == int'(RSP_DEPTH))
                else $error("credit invariant broken");
        end
    end

endmodule

// File: tb/tb_rewire_cmd_issuer.sv
// Self-checking bench for rewire_cmd_issuer: a stand-in pipeline, a
// queue-based reference model compared every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_rewire_cmd_issuer;

    localparam int          CMD_DEPTH = 4;
    localparam int          RSP_DEPTH = 4;
    localparam int          LAT       = 2;
    localparam logic [9:0]  NOP_WORD  = 10'h300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_data = 10'h000;
    logic [9:0]  dut_in;
    logic [15:0] dut_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_issued = 0;
    int run_len = 0;
    int max_run = 0;
    int n_sim = 0;

    rewire_cmd_issuer #(
        .CMD_DEPTH (CMD_DEPTH),
        .RSP_DEPTH (RSP_DEPTH),
        .LAT       (LAT),
        .NOP_WORD  (NOP_WORD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pipeline stand-in: result is a fixed function of the word.
    function automatic logic [15:0] f(input logic [9:0] w);
        return 16'hA800 | {6'b000000, w};
    endfunction

    // LAT-1 register stages after dut_in; dut_out is combinational from them.
    logic [15:0] pipe [LAT-1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT - 1; k++) pipe[k] <= 16'h0000;
        end else begin
            pipe[0] <= f(dut_in);
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign dut_out = pipe[LAT-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queues of commands and responses plus LAT in-flight slots.
    logic [9:0]  m_cmdq [$];
    logic [15:0] m_rspq [$];
    logic        m_sv [LAT];
    logic [9:0]  m_sw [LAT];
    logic [9:0]  m_dut_in = NOP_WORD;

    function automatic int m_inflight();
        int c = 0;
        for (int k = 0; k < LAT; k++) c += int'(m_sv[k]);
        return c;
    endfunction

    function automatic int m_credits();
        return RSP_DEPTH - m_rspq.size() - m_inflight();
    endfunction

    initial begin
        for (int k = 0; k < LAT; k++) begin
            m_sv[k] = 1'b0;
            m_sw[k] = 10'h000;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cmdq.delete();
                m_rspq.delete();
                for (int k = 0; k < LAT; k++) m_sv[k] = 1'b0;
                m_dut_in = NOP_WORD;
            end else begin
                bit pop, iss, acc, capt;
                logic [9:0] cap_w;
                pop  = (m_rspq.size() > 0) && rsp_ready;
                iss  = (m_cmdq.size() > 0) && (m_credits() > 0);
                acc  = cmd_valid && (m_cmdq.size() < CMD_DEPTH);
                capt = m_sv[LAT-1];
                cap_w = m_sw[LAT-1];
                if (iss && pop && m_credits() == 1) n_sim++;
                if (pop) void'(m_rspq.pop_front());
                if (capt) m_rspq.push_back(f(cap_w));
                for (int k = LAT - 1; k > 0; k--) begin
                    m_sv[k] = m_sv[k-1];
                    m_sw[k] = m_sw[k-1];
                end
                if (iss) begin
                    m_sw[0] = m_cmdq.pop_front();
                    m_sv[0] = 1'b1;
                    m_dut_in = m_sw[0];
                end else begin
                    m_sv[0] = 1'b0;
                    m_dut_in = NOP_WORD;
                end
                if (acc) m_cmdq.push_back(cmd_data);
            end
        end
    end

    // Compare every cycle on the falling edge; also count issued words.
    initial begin
        forever begin
            @(negedge clk);
            check("dut_in", 32'(dut_in), 32'(m_dut_in));
            check("cmd_ready", 32'(cmd_ready), 32'(m_cmdq.size() < CMD_DEPTH));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rspq.size() > 0));
            check("rsp_data", 32'(rsp_data), (m_rspq.size() > 0) ? 32'(m_rspq[0]) : 32'h0);
            check("busy", 32'(busy),
                  32'((m_cmdq.size() > 0) || (m_inflight() > 0) || (m_rspq.size() > 0)));
            check("credits", 32'(dut.r_credits), 32'(m_credits()));
            if (dut_in !== NOP_WORD) begin
                n_issued++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] w);
        int   guard;
        logic rdy;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        do begin
            rdy = cmd_ready;
            tick();
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) check("push timeout", 32'(rdy), 32'h1);
        cmd_valid = 1'b0;
    endtask

    task automatic single_cmd(input logic [9:0] w, input logic [15:0] exp);
        rsp_ready = 1'b0;
        push(w);
        check("single busy E0", 32'(busy), 32'h1);
        check("single dut_in E0", 32'(dut_in), 32'h300);
        tick();
        check("single dut_in E1", 32'(dut_in), 32'(w));
        tick();
        check("single dut_in E2", 32'(dut_in), 32'h300);
        check("single rsp_valid E2", 32'(rsp_valid), 32'h0);
        tick();
        check("single rsp_valid E3", 32'(rsp_valid), 32'h1);
        check("single rsp_data E3", 32'(rsp_data), 32'(exp));
        tick();
        tick();
        check("single rsp held", 32'(rsp_valid), 32'h1);
        check("single rsp_data held", 32'(rsp_data), 32'(exp));
        rsp_ready = 1'b1;
        tick();
        check("single rsp popped", 32'(rsp_valid), 32'h0);
        check("single idle", 32'(busy), 32'h0);
    endtask

    initial begin
        int got;
        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset dut_in", 32'(dut_in), 32'h300);
        check("reset cmd_ready", 32'(cmd_ready), 32'h1);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", 32'(rsp_data), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset credits", 32'(dut.r_credits), 32'h4);
        tick();
        rst = 1'b0;
        tick();

        single_cmd(10'h0A5, 16'hA8A5);

        // Back-to-back burst with a ready consumer.
        rsp_ready = 1'b1;
        n_issued = 0;
        max_run = 0;
        push(10'h011);
        push(10'h122);
        push(10'h233);
        push(10'h344);
        repeat (8) tick();
        check("burst issued", 32'(n_issued), 32'h4);
        check("burst no bubbles", 32'(max_run), 32'h4);
        check("burst idle", 32'(busy), 32'h0);

        // Backpressure: only RSP_DEPTH words may issue.
        rsp_ready = 1'b0;
        n_issued = 0;
        n_sim = 0;
        for (int i = 0; i < 8; i++) push(10'h100 + 10'(i));
        repeat (4) tick();
        check("bp issued", 32'(n_issued), 32'h4);
        check("bp cmd full", 32'(cmd_ready), 32'h0);
        check("bp nop", 32'(dut_in), 32'h300);
        check("bp rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp credits", 32'(dut.r_credits), 32'h0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            if (rsp_valid) begin
                check("drain order", 32'(rsp_data), 32'h0000A900 + 32'(got));
                got++;
            end
            tick();
        end
        check("drain count", 32'(got), 32'h8);
        check("issue+pop at credits=1 seen", 32'(n_sim > 0), 32'h1);
        repeat (4) tick();
        check("drain idle", 32'(busy), 32'h0);

        // Reset with two words in flight.
        push(10'h1C1);
        push(10'h1C2);
        push(10'h1C3);
        check("inflight before reset", 32'(m_inflight()), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("midrst dut_in", 32'(dut_in), 32'h300);
        check("midrst cmd_ready", 32'(cmd_ready), 32'h1);
        check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst credits", 32'(dut.r_credits), 32'h4);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post reset quiet", 32'(rsp_valid), 32'h0);
        end
        check("post reset credits", 32'(dut.r_credits), 32'h4);
        single_cmd(10'h0A5, 16'hA8A5);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
